// File: rtl/clock_gen_pkg.sv
// rtl/clock_gen_pkg.sv - state encodings and divider arithmetic shared by clock_gen
package clock_gen_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PHASE_WAIT = 2'd1;
    localparam logic [1:0] ST_RUN        = 2'd2;
    localparam logic [1:0] ST_STOPPING   = 2'd3;

    function automatic int calc_div(input int ref_khz, input int freq_khz);
        return ref_khz / freq_khz;
    endfunction

    // Rounded high time, clamped so both halves of the period are at least one cycle.
    function automatic int calc_high(input int div, input int duty);
        int h;
        h = (div * duty + 50) / 100;
        if (h < 1) h = 1;
        if (h > div - 1) h = div - 1;
        return h;
    endfunction

    function automatic int cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/clock_gen_sync.sv
// rtl/clock_gen_sync.sv - two-flop synchronizer for the asynchronous enable request
module clock_gen_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/clock_gen.sv
// rtl/clock_gen.sv - glitch-free programmable divided clock/strobe; CLKGEN_SYNC_EN adds an enable synchronizer
module clock_gen
    import clock_gen_pkg::*;
#(
    parameter int REF_FREQ_KHZ = 1200000,
    parameter int FREQ         = 100000,
    parameter int DUTY         = 50,
    parameter int PHASE        = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic clk_out,
    output logic active
);

    localparam int DIV  = calc_div(REF_FREQ_KHZ, FREQ);
    localparam int HIGH = calc_high(DIV, DUTY);
    localparam int CW   = cnt_width(DIV);
    localparam int PW   = (PHASE > 1) ? $clog2(PHASE) : 1;

    localparam logic [CW-1:0] HIGH_C   = CW'(HIGH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'((PHASE > 0) ? PHASE - 1 : 0);

    generate
        if (DIV < 2 || DUTY < 1 || DUTY > 99) begin : g_bad_cfg
            $error("clock_gen: DIV must be >= 2 and DUTY within 1..99");
        end
    endgenerate

    logic en_s;

`ifdef CLKGEN_SYNC_EN
    clock_gen_sync u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (enable),
        .q_o   (en_s)
    );
`else
    assign en_s = enable;
`endif

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ph_q, ph_d;
    logic          clk_out_q, clk_out_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        ph_d      = '0;
        clk_out_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_s) begin
                    if (PHASE > 0) state_d = ST_PHASE_WAIT;
                    else           state_d = ST_RUN;
                end
            end
            ST_PHASE_WAIT: begin
                if (!en_s)               state_d = ST_IDLE;
                else if (ph_q == PH_LAST) state_d = ST_RUN;
                else                     ph_d    = ph_q + PW'(1);
            end
            ST_RUN, ST_STOPPING: begin
                // Output and counter keep running while stopping so the period always completes.
                clk_out_d = (cnt_q < HIGH_C);
                cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
                if (en_s)                     state_d = ST_RUN;
                else if (state_q == ST_STOPPING && cnt_q == CNT_LAST)
                                              state_d = ST_IDLE;
                else                          state_d = ST_STOPPING;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ph_q      <= '0;
            clk_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ph_q      <= ph_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign clk_out = clk_out_q;
    assign active  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clock_gen.sv
// tb/tb_clock_gen.sv - directed self-checking bench for clock_gen (default build)
module tb_clock_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, en_a = 1'b0, co_a, act_a;
    logic rst_b = 1'b1, en_b = 1'b0, co_b, act_b;
    logic rst_c = 1'b1, en_c = 1'b0, co_c, act_c;
    logic rst_d = 1'b1, en_d = 1'b0, co_d, act_d;

    int checks   = 0;
    int failures = 0;

    clock_gen #(.REF_FREQ_KHZ(1200000), .FREQ(100000), .DUTY(50), .PHASE(0)) u_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .clk_out(co_a), .active(act_a));
    clock_gen #(.REF_FREQ_KHZ(1200000), .FREQ(400000), .DUTY(50), .PHASE(0)) u_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .clk_out(co_b), .active(act_b));
    clock_gen #(.REF_FREQ_KHZ(1200000), .FREQ(600000), .DUTY(50), .PHASE(0)) u_c (
        .clk(clk), .rst(rst_c), .enable(en_c), .clk_out(co_c), .active(act_c));
    clock_gen #(.REF_FREQ_KHZ(1200000), .FREQ(100000), .DUTY(50), .PHASE(5)) u_d (
        .clk(clk), .rst(rst_d), .enable(en_d), .clk_out(co_d), .active(act_d));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0b expected=%0b", tag, idx, obs, exp);
        end
    endtask

    initial begin
        // Reset state of all instances
        tick(); tick();
        chk("rst_co_a", 0, co_a, 1'b0);  chk("rst_act_a", 0, act_a, 1'b0);
        chk("rst_co_b", 0, co_b, 1'b0);  chk("rst_co_c", 0, co_c, 1'b0);
        chk("rst_co_d", 0, co_d, 1'b0);  chk("rst_act_d", 0, act_d, 1'b0);
        rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;
        tick();
        chk("idle_act_a", 0, act_a, 1'b0);

        // DIV=12/6, DIV=3/2, DIV=2/1 free-running waveforms
        en_a = 1; en_b = 1; en_c = 1;
        tick();
        chk("start_co_a", 0, co_a, 1'b0);  chk("start_act_a", 0, act_a, 1'b1);
        chk("start_co_b", 0, co_b, 1'b0);  chk("start_co_c", 0, co_c, 1'b0);
        for (int i = 0; i < 24; i++) begin
            tick();
            chk("wave_a", i, co_a, ((i % 12) < 6) ? 1'b1 : 1'b0);
            chk("wave_b", i, co_b, ((i % 3) < 2) ? 1'b1 : 1'b0);
            chk("wave_c", i, co_c, ((i % 2) < 1) ? 1'b1 : 1'b0);
        end

        // Drop enable at cnt=2: pulse completes, then full low half, then idle
        rst_a = 1; en_a = 0; tick(); rst_a = 0;
        en_a = 1;
        tick(); tick(); tick();
        chk("drop_pre_co", 0, co_a, 1'b1);
        en_a = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            chk("drop_co", j, co_a, (j < 4) ? 1'b1 : 1'b0);
            chk("drop_act", j, act_a, (j < 9) ? 1'b1 : 1'b0);
        end

        // Drop and re-raise within one period: periods continue unbroken
        rst_a = 1; tick(); rst_a = 0;
        en_a = 1;
        tick();
        for (int k = 1; k <= 36; k++) begin
            tick();
            chk("rearm_co", k, co_a, (((k - 1) % 12) < 6) ? 1'b1 : 1'b0);
            chk("rearm_act", k, act_a, 1'b1);
            if (k == 3) en_a = 0;
            if (k == 5) en_a = 1;
        end

        // Reset in the middle of a high half, then restart from cnt=0
        tick();
        chk("pre_rst_co", 0, co_a, 1'b1);
        rst_a = 1;
        tick();
        chk("midrst_co", 0, co_a, 1'b0);  chk("midrst_act", 0, act_a, 1'b0);
        tick();
        chk("midrst_act2", 0, act_a, 1'b0);
        rst_a = 0;
        tick();
        chk("restart_co", 0, co_a, 1'b0);  chk("restart_act", 0, act_a, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("restart_wave", i, co_a, (i < 6) ? 1'b1 : 1'b0);
        end

        // PHASE=5: first high six edges after the accepting edge
        en_d = 1;
        tick();
        chk("ph_act", 0, act_d, 1'b1);  chk("ph_co", 0, co_d, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("ph_wave", i, co_d, (i >= 6) ? 1'b1 : 1'b0);
        end

        // Short enable pulse during phase wait emits nothing
        rst_d = 1; en_d = 0; tick(); rst_d = 0;
        en_d = 1;
        tick(); tick(); tick();
        en_d = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("ph_short_co", i, co_d, 1'b0);
            chk("ph_short_act", i, act_d, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
